// File: rtl/vpg_mode_ctrl.sv
// -----------------------------------------------------------------------------
// vpg_mode_ctrl
//
// Owns the eight live timing registers that drive the HDMI pattern generator
// and sequences a glitch-free video mode change:
//   wait for a frame boundary -> hold generator in reset -> request pixel-PLL
//   reconfiguration -> load new timing -> wait for PLL lock -> settle ->
//   release the generator.
//
// Ports:
//   clk, reset        controller clock and synchronous active-high reset
//   mode_req          one-cycle request strobe, only honoured while idle
//   mode_sel          requested mode (0=640x480, 1=1920x1080, 2=1280x720,
//                     3=custom shadow set)
//   cfg_we/addr/data  write port for the custom shadow timing registers
//   vpg_vs            generator vsync, already synchronised to clk
//   pll_req/pll_mode  PLL reconfiguration request (level) and target mode
//   pll_ack           PLL reconfigured and locked
//   gen_rst_n         active-low reset to the generator
//   h_*/v_*           live timing registers
//   cur_mode          mode currently loaded into the live registers
//   busy              high whenever a sequence (or boot settle) is running
//   done              one-cycle pulse on return to idle
//   err               sticky flags: bit0 frame timeout, bit1 PLL timeout
// -----------------------------------------------------------------------------
module vpg_mode_ctrl #(
   parameter int unsigned SETTLE_CYCLES = 16,
   parameter int unsigned FRAME_TIMEOUT = 2000000,
   parameter int unsigned PLL_TIMEOUT   = 1000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mode_req,
   input  logic [1:0]  mode_sel,
   input  logic        cfg_we,
   input  logic [2:0]  cfg_addr,
   input  logic [11:0] cfg_data,
   input  logic        vpg_vs,
   output logic        pll_req,
   output logic [1:0]  pll_mode,
   input  logic        pll_ack,
   output logic        gen_rst_n,
   output logic [11:0] h_total,
   output logic [11:0] h_sync,
   output logic [11:0] h_start,
   output logic [11:0] h_end,
   output logic [11:0] v_total,
   output logic [11:0] v_sync,
   output logic [11:0] v_start,
   output logic [11:0] v_end,
   output logic [1:0]  cur_mode,
   output logic        busy,
   output logic        done,
   output logic [1:0]  err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_FRAME,
      S_HOLD,
      S_LOAD,
      S_WAIT_PLL,
      S_SETTLE
   } state_t;

   // Timing sets packed as [7:0][11:0]; element 0 is h_total, element 7 is v_end.
   localparam logic [7:0][11:0] MODE0 = {12'd514, 12'd34, 12'd1, 12'd524,
                                         12'd781, 12'd141, 12'd95, 12'd799};
   localparam logic [7:0][11:0] MODE1 = {12'd1120, 12'd40, 12'd4, 12'd1124,
                                         12'd2109, 12'd189, 12'd43, 12'd2199};
   localparam logic [7:0][11:0] MODE2 = {12'd744, 12'd24, 12'd4, 12'd749,
                                         12'd1537, 12'd257, 12'd39, 12'd1649};

   localparam logic [31:0] FRAME_LAST  = 32'(FRAME_TIMEOUT - 1);
   localparam logic [31:0] PLL_LAST    = 32'(PLL_TIMEOUT - 1);
   localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);

   state_t            state_q, state_d;
   logic [31:0]       cnt_q, cnt_d;
   logic [31:0]       cnt_inc;
   logic [1:0]        tgt_q, tgt_d;
   logic              vs_prev_q, vs_prev_d;
   logic [7:0][11:0]  live_q, live_d;
   logic [7:0][11:0]  shadow_q, shadow_d;
   logic [7:0][11:0]  tgt_set;
   logic [1:0]        cur_mode_q, cur_mode_d;
   logic              pll_req_q, pll_req_d;
   logic [1:0]        pll_mode_q, pll_mode_d;
   logic              gen_rst_n_q, gen_rst_n_d;
   logic              done_q, done_d;
   logic [1:0]        err_q, err_d;
   logic              vs_rise;

   // Timing set selected by the latched target mode; mode 3 uses the shadow copy.
   always_comb begin
      tgt_set = MODE0;
      unique case (tgt_q)
         2'd0:    tgt_set = MODE0;
         2'd1:    tgt_set = MODE1;
         2'd2:    tgt_set = MODE2;
         default: tgt_set = shadow_q;
      endcase
   end

   // Next-state logic for the sequencer and all registered outputs.
   // The counter saturates and is cleared on every state entry.
   always_comb begin
      state_d     = state_q;
      cnt_inc     = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
      cnt_d       = cnt_inc;
      tgt_d       = tgt_q;
      vs_prev_d   = vpg_vs;
      live_d      = live_q;
      shadow_d    = shadow_q;
      cur_mode_d  = cur_mode_q;
      pll_req_d   = pll_req_q;
      pll_mode_d  = pll_mode_q;
      gen_rst_n_d = gen_rst_n_q;
      done_d      = 1'b0;
      err_d       = err_q;
      vs_rise     = vpg_vs & ~vs_prev_q;

      // Shadow writes are accepted in every state; they reach the live
      // registers only through a later load.
      if (cfg_we) begin
         shadow_d[cfg_addr] = cfg_data;
      end

      unique case (state_q)
         S_IDLE: begin
            cnt_d = 32'd0;
            if (mode_req) begin
               tgt_d   = mode_sel;
               err_d   = 2'b00;
               state_d = S_WAIT_FRAME;
            end
         end
         S_WAIT_FRAME: begin
            // A vsync edge wins over a simultaneous timeout.
            if (vs_rise || (cnt_q == FRAME_LAST)) begin
               if (!vs_rise) begin
                  err_d[0] = 1'b1;
               end
               gen_rst_n_d = 1'b0;
               pll_req_d   = 1'b1;
               pll_mode_d  = tgt_q;
               cnt_d       = 32'd0;
               state_d     = S_HOLD;
            end
         end
         S_HOLD: begin
            cnt_d   = 32'd0;
            state_d = S_LOAD;
         end
         S_LOAD: begin
            live_d     = tgt_set;
            cur_mode_d = tgt_q;
            cnt_d      = 32'd0;
            state_d    = S_WAIT_PLL;
         end
         S_WAIT_PLL: begin
            if (pll_ack || (cnt_q == PLL_LAST)) begin
               if (!pll_ack) begin
                  err_d[1] = 1'b1;
               end
               pll_req_d = 1'b0;
               cnt_d     = 32'd0;
               state_d   = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (cnt_q == SETTLE_LAST) begin
               gen_rst_n_d = 1'b1;
               done_d      = 1'b1;
               cnt_d       = 32'd0;
               state_d     = S_IDLE;
            end
         end
         default: begin
            cnt_d   = 32'd0;
            state_d = S_IDLE;
         end
      endcase
   end

   // State registers. Reset drops straight into SETTLE so boot releases the
   // generator without a PLL handshake.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_SETTLE;
         cnt_q       <= 32'd0;
         tgt_q       <= 2'd0;
         vs_prev_q   <= 1'b0;
         live_q      <= MODE0;
         shadow_q    <= MODE0;
         cur_mode_q  <= 2'd0;
         pll_req_q   <= 1'b0;
         pll_mode_q  <= 2'd0;
         gen_rst_n_q <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 2'b00;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         tgt_q       <= tgt_d;
         vs_prev_q   <= vs_prev_d;
         live_q      <= live_d;
         shadow_q    <= shadow_d;
         cur_mode_q  <= cur_mode_d;
         pll_req_q   <= pll_req_d;
         pll_mode_q  <= pll_mode_d;
         gen_rst_n_q <= gen_rst_n_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign h_total   = live_q[0];
   assign h_sync    = live_q[1];
   assign h_start   = live_q[2];
   assign h_end     = live_q[3];
   assign v_total   = live_q[4];
   assign v_sync    = live_q[5];
   assign v_start   = live_q[6];
   assign v_end     = live_q[7];
   assign cur_mode  = cur_mode_q;
   assign pll_req   = pll_req_q;
   assign pll_mode  = pll_mode_q;
   assign gen_rst_n = gen_rst_n_q;
   assign done      = done_q;
   assign err       = err_q;
   assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_vpg_mode_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vpg_mode_ctrl
//
// Scoreboard bench for vpg_mode_ctrl. Each mode request pushes the expected
// completion (cycle of the done pulse, loaded mode, live timing, error flags)
// into a queue; a monitor pops and compares whenever done pulses.
// -----------------------------------------------------------------------------
module tb_vpg_mode_ctrl;

   localparam int S  = 16;
   localparam int FT = 300;
   localparam int PT = 120;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        mode_req = 1'b0;
   logic [1:0]  mode_sel = 2'd0;
   logic        cfg_we = 1'b0;
   logic [2:0]  cfg_addr = 3'd0;
   logic [11:0] cfg_data = 12'd0;
   logic        vpg_vs = 1'b0;
   logic        pll_ack = 1'b0;
   logic        pll_req;
   logic [1:0]  pll_mode;
   logic        gen_rst_n;
   logic [11:0] h_total, h_sync, h_start, h_end;
   logic [11:0] v_total, v_sync, v_start, v_end;
   logic [1:0]  cur_mode;
   logic        busy;
   logic        done;
   logic [1:0]  err;

   vpg_mode_ctrl #(
      .SETTLE_CYCLES(S),
      .FRAME_TIMEOUT(FT),
      .PLL_TIMEOUT(PT)
   ) dut (
      .clk(clk), .reset(reset),
      .mode_req(mode_req), .mode_sel(mode_sel),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .vpg_vs(vpg_vs),
      .pll_req(pll_req), .pll_mode(pll_mode), .pll_ack(pll_ack),
      .gen_rst_n(gen_rst_n),
      .h_total(h_total), .h_sync(h_sync), .h_start(h_start), .h_end(h_end),
      .v_total(v_total), .v_sync(v_sync), .v_start(v_start), .v_end(v_end),
      .cur_mode(cur_mode), .busy(busy), .done(done), .err(err)
   );

   // Free-running controller clock
   always #5 clk = ~clk;

   // Cycle counter, advanced on every active edge
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;

   typedef struct {
      int               mode;
      logic [7:0][11:0] live;
      int               err;
      int               done_cyc;
   } exp_t;

   exp_t sb[$];

   // Reference timing table, element order h_total..v_end
   int preset_tbl [3][8] = '{
      '{799, 95, 141, 781, 524, 1, 34, 514},
      '{2199, 43, 189, 2109, 1124, 4, 40, 1120},
      '{1649, 39, 257, 1537, 749, 4, 24, 744}
   };
   int shadow_model [8];
   string reg_names [8] = '{"h_total", "h_sync", "h_start", "h_end",
                            "v_total", "v_sync", "v_start", "v_end"};

   logic [7:0][11:0] live_obs;
   assign live_obs = {v_end, v_start, v_sync, v_total, h_end, h_start, h_sync, h_total};

   // One comparison: counts it and reports a FAIL line on mismatch
   task automatic checkOutput(input string name, input int actual, input int expected);
      tests++;
      if (actual != expected) begin
         fails++;
         $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Monitor: every done pulse retires the oldest expected completion
   always @(negedge clk) begin : monitor
      exp_t e;
      if (!reset && done) begin
         if (sb.size() == 0) begin
            checkOutput("unexpected_done", 1, 0);
         end else begin
            e = sb.pop_front();
            checkOutput("done_cycle", cyc, e.done_cyc);
            checkOutput("cur_mode", int'(cur_mode), e.mode);
            checkOutput("err", int'(err), e.err);
            for (int i = 0; i < 8; i++) begin
               checkOutput(reg_names[i], int'(live_obs[i]), int'(e.live[i]));
            end
            checkOutput("gen_rst_n_at_done", int'(gen_rst_n), 1);
            checkOutput("pll_req_at_done", int'(pll_req), 0);
         end
      end
   end

   // Live timing must never move while the generator is running
   logic [7:0][11:0] prev_live = '0;
   logic             prev_gen = 1'b0;
   always @(negedge clk) begin
      if (prev_gen && gen_rst_n && (live_obs != prev_live)) begin
         fails++;
         $display("[TB] FAIL live_stable: live regs changed with gen_rst_n=1 (cycle %0d)", cyc);
      end
      prev_live = live_obs;
      prev_gen  = gen_rst_n;
   end

   task automatic cfgWrite(input int addr, input int data);
      @(negedge clk);
      cfg_we   = 1'b1;
      cfg_addr = 3'(addr);
      cfg_data = 12'(data);
      shadow_model[addr] = data;
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   // Reset pulse, reset-state checks, then boot settle tracked via the scoreboard
   task automatic doReset();
      exp_t x;
      int   c0;
      @(negedge clk);
      reset    = 1'b1;
      mode_req = 1'b0;
      cfg_we   = 1'b0;
      vpg_vs   = 1'b0;
      pll_ack  = 1'b0;
      @(negedge clk);
      checkOutput("rst_pll_req", int'(pll_req), 0);
      checkOutput("rst_gen_rst_n", int'(gen_rst_n), 0);
      checkOutput("rst_h_total", int'(h_total), 799);
      checkOutput("rst_v_end", int'(v_end), 514);
      checkOutput("rst_cur_mode", int'(cur_mode), 0);
      checkOutput("rst_err", int'(err), 0);
      checkOutput("rst_busy", int'(busy), 1);
      checkOutput("rst_done", int'(done), 0);
      sb.delete();
      for (int i = 0; i < 8; i++) shadow_model[i] = preset_tbl[0][i];
      reset = 1'b0;
      c0 = cyc;
      x.mode = 0;
      x.err = 0;
      x.done_cyc = c0 + S;
      for (int i = 0; i < 8; i++) x.live[i] = 12'(preset_tbl[0][i]);
      sb.push_back(x);
      for (int k = 0; k < S + 3; k++) begin
         @(negedge clk);
         if (cyc == c0 + S - 1) checkOutput("boot_gen_rst_n_low", int'(gen_rst_n), 0);
      end
      checkOutput("boot_busy", int'(busy), 0);
      checkOutput("boot_pll_req", int'(pll_req), 0);
      checkOutput("boot_gen_rst_n_high", int'(gen_rst_n), 1);
      checkOutput("boot_sb_drained", sb.size(), 0);
   endtask

   // One mode change. e: WAIT_FRAME cycle index of the vsync edge (-1 = never).
   // a: WAIT_PLL cycle index of pll_ack (-1 = already high on entry, -2 = never).
   // extra_req: pulse mode_req during WAIT_PLL. abort_at: return early at that
   // relative cycle (-1 = run to completion).
   task automatic applyStimulus(input int m, input int e, input int a,
                                input bit extra_req, input int abort_at);
      exp_t x;
      int   eff_e, eff_a, lat, acc, rel, wa, wd;
      eff_e = (e < 0) ? FT - 1 : e;
      eff_a = (a == -2) ? PT - 1 : ((a == -1) ? 0 : a);
      lat   = eff_e + eff_a + 4 + S;
      @(negedge clk);
      mode_req = 1'b1;
      mode_sel = 2'(m);
      acc = cyc + 1;
      x.mode = m;
      x.err = ((e < 0) ? 1 : 0) | ((a == -2) ? 2 : 0);
      x.done_cyc = acc + lat;
      for (int i = 0; i < 8; i++)
         x.live[i] = (m == 3) ? 12'(shadow_model[i]) : 12'(preset_tbl[m][i]);
      sb.push_back(x);
      for (int k = 0; k < lat + 4; k++) begin
         @(negedge clk);
         rel = cyc - acc;
         mode_req = 1'b0;
         cfg_we   = 1'b0;
         if (abort_at >= 0 && rel == abort_at) return;
         vpg_vs = (e >= 0) && (rel >= e) && (rel < e + 3);
         if (a >= 0)       pll_ack = (rel == eff_e + 3 + a);
         else if (a == -1) pll_ack = (rel >= eff_e + 1) && (rel <= eff_e + 3);
         else              pll_ack = 1'b0;
         if (rel == eff_e + 3) begin
            checkOutput("wp_pll_req", int'(pll_req), 1);
            checkOutput("wp_pll_mode", int'(pll_mode), m);
            checkOutput("wp_gen_rst_n", int'(gen_rst_n), 0);
            checkOutput("wp_busy", int'(busy), 1);
            // Shadow write after the load: must only affect a later load
            wa = $urandom_range(0, 7);
            wd = $urandom_range(0, 4095);
            cfg_we   = 1'b1;
            cfg_addr = 3'(wa);
            cfg_data = 12'(wd);
            shadow_model[wa] = wd;
         end
         if (extra_req && rel == eff_e + 4) begin
            mode_req = 1'b1;
            mode_sel = 2'(m ^ 1);
         end
      end
      checkOutput("idle_busy", int'(busy), 0);
      checkOutput("err_sticky", int'(err), x.err);
      checkOutput("sb_drained", sb.size(), 0);
   endtask

   initial begin
      int m, e, a;
      doReset();
      applyStimulus(1, 50, 10, 1'b0, -1);
      cfgWrite(0, 1055);
      cfgWrite(7, 628);
      applyStimulus(3, 20, 5, 1'b0, -1);
      checkOutput("custom_h_total", int'(h_total), 1055);
      checkOutput("custom_v_end", int'(v_end), 628);
      applyStimulus(3, 4, 2, 1'b0, -1);
      applyStimulus(2, -1, 3, 1'b0, -1);
      applyStimulus(0, 10, -2, 1'b0, -1);
      applyStimulus(1, 0, -1, 1'b0, -1);
      applyStimulus(1, 7, 0, 1'b0, -1);
      applyStimulus(2, 8, 6, 1'b1, -1);
      for (int r = 0; r < 8; r++) begin
         cfgWrite($urandom_range(0, 7), $urandom_range(0, 4095));
         cfgWrite($urandom_range(0, 7), $urandom_range(0, 4095));
         m = $urandom_range(0, 3);
         e = $urandom_range(0, 60);
         a = $urandom_range(0, 20);
         applyStimulus(m, e, a, 1'b0, -1);
      end
      // Abort a mode-2 change while pll_req is still high
      applyStimulus(2, 5, -2, 1'b0, 5 + 3 + 10);
      doReset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Global time bound
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish (tests %0d)", tests);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
